// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO slice.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [$clog2(DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH):0]   cnt_t;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_mem import fifo_pkg::*; #(
  parameter int MEM_W     = DATA_WIDTH,
  parameter int MEM_DEPTH = DEPTH,
  parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [MEM_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic [MEM_W-1:0]  rd_data
);

  logic [MEM_W-1:0] mem_r [MEM_DEPTH];
  logic [MEM_W-1:0] rd_data_r;

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {MEM_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_top_sync.sv
// Single-clock FIFO: pointer, occupancy and status logic around fifo_mem.
module fifo_top_sync #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_s;
  logic             empty_s;
  logic             push_acc_s;
  logic             pop_acc_s;

  // Status decode and accept/occupancy next-state from the pre-edge count.
  always_comb begin
    full_s      = (count_r == CNT_W'(DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    push_acc_s  = push & ~full_s;
    pop_acc_s   = pop & ~empty_s;
    count_nxt_s = count_r;
    case ({push_acc_s, pop_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers wrap naturally at DEPTH; error flags pulse for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= push & full_s;
      underflow_r <= pop & empty_s;
    end
  end

  fifo_mem #(
    .MEM_W     (DATA_WIDTH),
    .MEM_DEPTH (DEPTH),
    .MEM_AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (pop_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (data_out)
  );

  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_fifo_top_sync.sv
// Scoreboard bench for fifo_top_sync: queue model feeds expectations to a monitor.
module tb_fifo_top_sync;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_out;
  logic       pop_fire;
  int         n_tests;
  int         n_fail;

  fifo_top_sync dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic p, input logic [7:0] d, input logic q);
    int   sz;
    logic pa, pq, eo, eu;
    @(negedge clk);
    push    = p;
    data_in = d;
    pop     = q;
    sz = model_q.size();
    pa = p && (sz < 16);
    pq = q && (sz > 0);
    eo = p && (sz == 16);
    eu = q && (sz == 0);
    pop_fire = pq;
    if (pq) begin
      last_out = model_q.pop_front();
      exp_q.push_back(last_out);
    end
    if (pa) model_q.push_back(d);
    @(posedge clk);
    #2;
    chk("count", count, model_q.size());
    chk("full", full, model_q.size() == 16);
    chk("empty", empty, model_q.size() == 0);
    chk("overflow", overflow, eo);
    chk("underflow", underflow, eu);
    chk("data_out_hold", data_out, last_out);
    push     = 1'b0;
    pop      = 1'b0;
    pop_fire = 1'b0;
  endtask

  // Monitor: compares each read result against the scoreboard queue.
  initial begin
    forever begin
      @(posedge clk);
      if (pop_fire) begin
        #1;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fifo_order: read with empty scoreboard, got 0x%0h", data_out);
        end else begin
          chk("fifo_order", data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = 8'h00;
    pop_fire = 1'b0;
    last_out = 8'h00;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x01..0x10, then one rejected push of 0xAA.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", overflow, 0);

    // Drain in order, then underflow must hold 0x10.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_last", data_out, 8'h10);
    chk("drain_empty", empty, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", underflow, 1);
    chk("unf_hold", data_out, 8'h10);
    chk("unf_count", count, 0);

    // Simultaneous push/pop on empty, mid-level and full.
    step(1'b1, 8'h55, 1'b1);
    chk("sim_empty_unf", underflow, 1);
    chk("sim_empty_count", count, 1);
    chk("sim_empty_hold", data_out, 8'h10);
    step(1'b0, 8'h00, 1'b1);
    chk("sim_empty_read", data_out, 8'h55);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b1);
    chk("sim_mid_data", data_out, 8'h11);
    chk("sim_mid_count", count, 3);
    for (int i = 0; model_q.size() < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    chk("sim_full_ovf", overflow, 1);
    chk("sim_full_count", count, 15);
    chk("sim_full_data", data_out, 8'h22);

    // Wrap-around traffic held between 8 and 12 entries.
    while (model_q.size() > 10) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 64; i++) begin
      int   r;
      logic p, q;
      r = $urandom_range(0, 3);
      p = (r != 0);
      q = (r != 1);
      if (model_q.size() >= 12) begin
        p = 1'b0;
        q = 1'b1;
      end else if (model_q.size() <= 8) begin
        p = 1'b1;
        q = 1'b0;
      end else begin
        p = p;
      end
      step(p, 8'($urandom_range(1, 255)), q);
    end

    // Mid-cycle asynchronous reset with 5 entries stored.
    while (model_q.size() > 5) step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_count", count, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_data_out", data_out, 0);
    model_q.delete();
    last_out = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_unf", underflow, 1);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_read", data_out, 8'h77);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
